// File: rtl/uart_receiver.sv
// UART receiver: start bit, 8 data bits LSB first, even parity, one stop bit.
// A built-in baud generator produces the 16x sample tick selected by baud_select.
module uart_receiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] Rx_DATA,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic       Rx_FERROR,
  output logic       Rx_PERROR,
  output logic       Rx_VALID
);

  // Rounded clocks-per-tick for a given baud rate, evaluated at elaboration only.
  function automatic int div_of(input int baud);
    return (CLK_FREQ + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  localparam int                CNT_W     = $clog2(div_of(300) + 1);
  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state, w_next;
  logic                r_rx_meta, r_rx_sync;
  logic [2:0]          r_baud_sel;
  logic [CNT_W-1:0]    r_baud_cnt, w_div_last;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift, r_data;
  logic                r_par_bit, r_valid, r_ferr, r_perr;
  logic                w_tick, w_mid_start, w_bit_end, w_par_ok;
  logic                w_start_det, w_clr_ticks, w_shift_en, w_par_en, w_stop_en;

  // NOTE: the synchroniser resets to the idle line level so no phantom start bit follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= RxD;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_comb begin
    case (r_baud_sel)
      3'd0:    w_div_last = CNT_W'(div_of(300) - 1);
      3'd1:    w_div_last = CNT_W'(div_of(1200) - 1);
      3'd2:    w_div_last = CNT_W'(div_of(4800) - 1);
      3'd3:    w_div_last = CNT_W'(div_of(9600) - 1);
      3'd4:    w_div_last = CNT_W'(div_of(19200) - 1);
      3'd5:    w_div_last = CNT_W'(div_of(38400) - 1);
      3'd6:    w_div_last = CNT_W'(div_of(57600) - 1);
      default: w_div_last = CNT_W'(div_of(115200) - 1);
    endcase
  end

  // A change of baud_select restarts the divisor so the new rate starts with a full period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud_sel <= 3'd0;
      r_baud_cnt <= '0;
    end else if (baud_select != r_baud_sel) begin
      r_baud_sel <= baud_select;
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == w_div_last) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + CNT_W'(1);
    end
  end

  assign w_tick      = (r_baud_cnt == w_div_last) && (baud_select == r_baud_sel);
  assign w_mid_start = w_tick && (r_tick_cnt == TICK_MID);
  assign w_bit_end   = w_tick && (r_tick_cnt == TICK_LAST);
  assign w_par_ok    = ((^r_shift) == r_par_bit);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Dropping Rx_EN aborts any frame in progress.
  always_comb begin
    w_next = r_state;
    if (!Rx_EN) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (!r_rx_sync) w_next = S_START;
        S_START:  if (w_mid_start) w_next = r_rx_sync ? S_IDLE : S_DATA;
        S_DATA:   if (w_bit_end && (r_bit_cnt == 3'd7)) w_next = S_PARITY;
        S_PARITY: if (w_bit_end) w_next = S_STOP;
        S_STOP:   if (w_bit_end) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: every strobe gets a default before the case so no latch is inferred.
  always_comb begin
    w_start_det = 1'b0;
    w_clr_ticks = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_en   = 1'b0;
    if (Rx_EN) begin
      case (r_state)
        S_IDLE:   w_start_det = !r_rx_sync;
        S_START:  w_clr_ticks = w_mid_start;
        S_DATA:   w_shift_en  = w_bit_end;
        S_PARITY: w_par_en    = w_bit_end;
        S_STOP:   w_stop_en   = w_bit_end;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_clr_ticks) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_W'(1);
      end

      if (r_state != S_DATA)  r_bit_cnt <= '0;
      else if (w_shift_en)    r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_shift_en) r_shift   <= {r_rx_sync, r_shift[7:1]};
      if (w_par_en)   r_par_bit <= r_rx_sync;

      if (w_start_det) begin
        r_valid <= 1'b0;
        r_ferr  <= 1'b0;
        r_perr  <= 1'b0;
      end else if (w_stop_en) begin
        r_ferr  <= !r_rx_sync;
        r_perr  <= !w_par_ok;
        r_valid <= r_rx_sync && w_par_ok;
        if (r_rx_sync && w_par_ok) r_data <= r_shift;
      end
    end
  end

  assign Rx_DATA   = r_data;
  assign Rx_VALID  = r_valid;
  assign Rx_FERROR = r_ferr;
  assign Rx_PERROR = r_perr;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed plus randomized frames for uart_receiver, checked against a frame-level
// reference model (flag and data rules computed straight from the frame contents).
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_FERROR, Rx_PERROR, Rx_VALID;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_perr;

  // Flags/data captured the first time any status flag rises during the stop bit
  logic       snap_got;
  logic [7:0] snap_data;
  logic       snap_valid, snap_ferr, snap_perr;

  uart_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .Rx_DATA    (Rx_DATA),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .RxD        (RxD),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_VALID   (Rx_VALID)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int clks);
    RxD = b;
    wait_clks(clks);
  endtask

  function automatic void model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endfunction

  function automatic void model_start();
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endfunction

  // Even parity: the parity bit must make the total count of ones even.
  function automatic void model_frame(input logic [7:0] d, input logic par, input logic stop);
    logic want_par;
    want_par = ($countones(d) % 2) == 1;
    m_perr   = (par != want_par);
    m_ferr   = !stop;
    m_valid  = !m_perr && !m_ferr;
    if (m_valid) m_data = d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int bit_clks);
    model_start();
    snap_got   = 1'b0;
    snap_data  = 8'h00;
    snap_valid = 1'b0;
    snap_ferr  = 1'b0;
    snap_perr  = 1'b0;
    send_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) send_bit(d[i], bit_clks);
    send_bit(par, bit_clks);
    RxD = stop;
    for (int c = 0; c < (bit_clks * 5) / 8; c++) begin
      @(negedge clk);
      if (!snap_got && (Rx_VALID || Rx_FERROR || Rx_PERROR)) begin
        snap_got   = 1'b1;
        snap_data  = Rx_DATA;
        snap_valid = Rx_VALID;
        snap_ferr  = Rx_FERROR;
        snap_perr  = Rx_PERROR;
      end
    end
    model_frame(d, par, stop);
    // A low stop bit looks like a new start; park the receiver and restore the idle line.
    if (!stop) begin
      Rx_EN = 1'b0;
      RxD   = 1'b1;
      wait_clks(10);
      Rx_EN = 1'b1;
      wait_clks(20);
    end
  endtask

  task automatic check_snap(input string tag);
    check({tag, "_valid"}, 8'(snap_valid), 8'(m_valid));
    check({tag, "_ferr"},  8'(snap_ferr),  8'(m_ferr));
    check({tag, "_perr"},  8'(snap_perr),  8'(m_perr));
    check({tag, "_data"},  snap_data,      m_data);
  endtask

  task automatic check_live(input string tag);
    check({tag, "_valid"}, 8'(Rx_VALID),  8'(m_valid));
    check({tag, "_ferr"},  8'(Rx_FERROR), 8'(m_ferr));
    check({tag, "_perr"},  8'(Rx_PERROR), 8'(m_perr));
    check({tag, "_data"},  Rx_DATA,       m_data);
  endtask

  initial begin
    logic [7:0] rnd_byte;
    logic [1:0] rnd_kind;
    logic       rnd_par;

    reset       = 1'b1;
    Rx_EN       = 1'b0;
    RxD         = 1'b1;
    baud_select = 3'b111;
    model_reset();
    wait_clks(5);
    reset = 1'b0;
    wait_clks(2);
    check_live("reset");

    Rx_EN = 1'b1;
    wait_clks(50);

    send_frame(8'hA5, 1'b0, 1'b1, 432);
    check_snap("good_a5");
    send_frame(8'h3C, 1'b1, 1'b1, 432);
    check_snap("perr_3c");
    send_frame(8'h01, 1'b1, 1'b0, 432);
    check_snap("ferr_01");

    // Short low glitch: rejected at the mid-start resample
    model_start();
    RxD = 1'b0;
    wait_clks(100);
    RxD = 1'b1;
    wait_clks(400);
    check_live("false_start");

    // Enable dropped partway through the data bits of 8'h5A
    model_start();
    send_bit(1'b0, 432);
    send_bit(1'b0, 432);
    send_bit(1'b1, 432);
    send_bit(1'b0, 432);
    Rx_EN = 1'b0;
    RxD   = 1'b1;
    wait_clks(10);
    Rx_EN = 1'b1;
    wait_clks(100);
    check_live("abort");

    send_frame(8'h5A, 1'b0, 1'b1, 432);
    check_snap("after_abort_5a");

    for (int f = 0; f < 2; f++) begin
      rnd_byte = 8'($urandom_range(0, 255));
      rnd_kind = 2'($urandom_range(0, 3));
      rnd_par  = (($countones(rnd_byte) % 2) == 1) ^ rnd_kind[0];
      send_frame(rnd_byte, rnd_par, !rnd_kind[1], 432);
      check_snap($sformatf("random%0d", f));
    end

    baud_select = 3'b011;
    wait_clks(20);
    send_frame(8'hFF, 1'b0, 1'b1, 5216);
    check_snap("baud9600_ff");

    // Line toggling every 500 ns at 115200: outputs stay known and exclusive
    baud_select = 3'b111;
    for (int i = 0; i < 120; i++) begin
      RxD = ~RxD;
      wait_clks(25);
      check("stress_no_x", 8'($isunknown({Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR})), 8'h00);
      check("stress_excl", 8'(Rx_VALID & (Rx_FERROR | Rx_PERROR)), 8'h00);
    end

    // Reset in the middle of a frame returns everything to reset values
    RxD = 1'b1;
    wait_clks(500);
    RxD = 1'b0;
    wait_clks(600);
    reset = 1'b1;
    wait_clks(2);
    model_reset();
    check_live("reset_midframe");
    reset = 1'b0;
    RxD   = 1'b1;
    wait_clks(5);
    check("post_reset_valid", 8'(Rx_VALID), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART serial receiver for the 50 MHz system clock domain.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Contains an internal baud-rate controller that generates a 16x oversampling tick from baud_select.
- Delivers the received byte with valid, parity-error and framing-error status flags to the host logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; used to derive the baud divisor table.
- OVERSAMPLE, 16, sample ticks per bit period.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Rx_DATA  output  8  last correctly received byte.
- baud_select  input  3  baud-rate selector.
- Rx_EN  input  1  receiver enable.
- RxD  input  1  serial line; idle level 1; asynchronous to clk.
- Rx_FERROR  output  1  framing error: stop bit sampled as 0.
- Rx_PERROR  output  1  parity error: even parity mismatch.
- Rx_VALID  output  1  frame received without error.
- Port order is exactly as listed.
- Clocking/reset decision: one clock (clk); reset is synchronous and active-high.

Behaviour:
- Reset: state IDLE; Rx_DATA=8'h00; Rx_VALID=0; Rx_FERROR=0; Rx_PERROR=0; all counters=0; synchroniser flops=1.
- Baud divisor: sample_tick pulses for one clk every N clks. N is selected by baud_select:
  - 000 → 300 baud, N=10417
  - 001 → 1200, N=2604
  - 010 → 4800, N=651
  - 011 → 9600, N=326
  - 100 → 19200, N=163
  - 101 → 38400, N=81
  - 110 → 57600, N=54
  - 111 → 115200, N=27
  - The divisor counter restarts when baud_select changes.
- Synchroniser: RxD passes through a 2-flop synchroniser; all logic uses the synchronised value.
- IDLE:
  - Wait for Rx_EN=1 and synchronised RxD=0.
  - On entry to START, clear Rx_VALID, Rx_FERROR and Rx_PERROR.
- START:
  - After 8 ticks (mid-bit), resample.
  - If the line is 1, treat it as a false start and return to IDLE (flags stay cleared).
  - Otherwise reset the tick counter and go to DATA.
- DATA:
  - Sample every 16 ticks (mid-bit).
  - Shift bits into a shift register LSB first; 8 bits, then go to PARITY.
- PARITY: sample at tick 16; compute expected = XOR of the 8 data bits (even parity).
- STOP:
  - Sample at tick 16.
  - Stop=0 → Rx_FERROR=1.
  - Parity mismatch → Rx_PERROR=1.
  - Both errors may assert together.
  - No error → Rx_DATA loaded with the shift register and Rx_VALID=1 on the same clk edge.
  - Return to IDLE.
- Latency: flags update on the clk edge following the mid-stop-bit tick. This is about 10.5 bit periods after the start edge, plus 2 clks of synchroniser delay.
- Flag lifetime: flags are levels. They hold until the next detected start bit or reset.
- Mutual exclusion: Rx_VALID is never 1 together with either error flag.
- Rx_DATA on errors: unchanged on error frames; it holds the last good byte.
- Rx_EN=0 mid-frame: abort and go to IDLE; the partial byte is discarded; flags and Rx_DATA are retained.
- reset mid-frame: has priority over everything and returns all state to reset values on that edge.
- A new start bit is accepted immediately after STOP completes; no extra idle bit is required.
- Outputs are never X/Z after the first reset edge, including with arbitrary RxD toggling.

Test Plan:
- Reset sequence: reset=1 for 5 clks with Rx_EN=0, then release → all outputs 0, Rx_DATA=8'h00.
- Good frame, 8'hA5: baud_select=111 (bit = 432 clks = 8640 ns), Rx_EN=1; send start, A5 LSB first, parity 0, stop 1 → Rx_VALID=1, Rx_DATA=8'hA5, Rx_FERROR=0, Rx_PERROR=0.
- Parity error: baud_select=111; send 8'h3C with parity 1 → Rx_PERROR=1, Rx_VALID=0, Rx_DATA stays 8'hA5.
- Framing error: baud_select=111; send 8'h01 with parity 1, stop 0 → Rx_FERROR=1, Rx_PERROR=0, Rx_VALID=0.
- False start and abort:
  - A 0-pulse of 100 clks on RxD → receiver returns to IDLE; no flags set.
  - Rx_EN dropped mid-frame → no flags; the next full frame (8'h5A) is received correctly.
- Rate and stress:
  - baud_select=011 (bit = 5216 clks); send 8'hFF with parity 0 → Rx_VALID=1, Rx_DATA=8'hFF.
  - Then RxD toggling every 500 ns for 60 µs at 111 → no X on outputs; Rx_VALID never high together with an error flag.
